// File: rtl/alu_issue_stage_if.sv
// Operand/control bus between the issue stage, its upstream decode feed and the ALU consumer.
// The stage takes the slave view; the surrounding pipeline (or a bench) takes the master view.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            flush_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] operand1_o;
    logic [XLEN-1:0] operand2_o;
    logic [3:0]      alu_control_o;
    logic            is_branch_o;
    logic            branch_ne_o;
    logic [XLEN-1:0] store_data_o;
    logic            illegal_o;

    modport slave (
        input  in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, operand1_o, operand2_o, alu_control_o,
               is_branch_o, branch_ne_o, store_data_o, illegal_o
    );

    modport master (
        output in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, operand1_o, operand2_o, alu_control_o,
               is_branch_o, branch_ne_o, store_data_o, illegal_o
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I execute-issue stage: decodes an instruction into ALU operands/control and holds
// the result in a single ID/EX register with valid/ready handshake, stall and flush.
module alu_issue_stage #(
    parameter int         XLEN         = 32,
    parameter logic [3:0] ILLEGAL_CODE = 4'b0000
) (
    input logic               clk_i,
    input logic               rst_ni,
    alu_issue_stage_if.slave  bus
);
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] store_data;
        logic [3:0]      ctrl;
        logic            is_branch;
        logic            branch_ne;
        logic            illegal;
    } dec_t;

    dec_t dec_d, dec_q;
    logic out_valid_q;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt_i, shamt_r;

    assign opcode = bus.instr_i[6:0];
    assign funct3 = bus.instr_i[14:12];
    assign funct7 = bus.instr_i[31:25];
    assign imm_i  = XLEN'($signed(bus.instr_i[31:20]));
    assign imm_s  = XLEN'($signed({bus.instr_i[31:25], bus.instr_i[11:7]}));
    assign imm_u  = XLEN'($signed({bus.instr_i[31:12], 12'b0}));
    // Shift amounts are masked to 5 bits here so the ALU can shift by the full operand2.
    assign shamt_i = XLEN'(bus.instr_i[24:20]);
    assign shamt_r = XLEN'(bus.rs2_data_i[4:0]);

    always_comb begin
        dec_d         = '0;
        dec_d.illegal = 1'b0;
        unique case (opcode)
            OP_R: begin
                dec_d.op1 = bus.rs1_data_i;
                dec_d.op2 = bus.rs2_data_i;
                if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_d.ctrl = ALU_SUB;
                end else if (funct7 != 7'b0000000) begin
                    dec_d.illegal = 1'b1;
                end else begin
                    case (funct3)
                        3'b000: dec_d.ctrl = ALU_ADD;
                        3'b001: begin dec_d.ctrl = ALU_SLL; dec_d.op2 = shamt_r; end
                        3'b011: dec_d.ctrl = ALU_SLTU;
                        3'b100: dec_d.ctrl = ALU_XOR;
                        3'b101: begin dec_d.ctrl = ALU_SRL; dec_d.op2 = shamt_r; end
                        3'b110: dec_d.ctrl = ALU_OR;
                        3'b111: dec_d.ctrl = ALU_AND;
                        default: dec_d.illegal = 1'b1;
                    endcase
                end
            end
            OP_I: begin
                dec_d.op1 = bus.rs1_data_i;
                dec_d.op2 = imm_i;
                case (funct3)
                    3'b000: dec_d.ctrl = ALU_ADD;
                    3'b011: dec_d.ctrl = ALU_SLTU;
                    3'b100: dec_d.ctrl = ALU_XOR;
                    3'b110: dec_d.ctrl = ALU_OR;
                    3'b111: dec_d.ctrl = ALU_AND;
                    3'b001: begin
                        dec_d.ctrl    = ALU_SLL;
                        dec_d.op2     = shamt_i;
                        dec_d.illegal = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        dec_d.ctrl    = ALU_SRL;
                        dec_d.op2     = shamt_i;
                        dec_d.illegal = (funct7 != 7'b0000000);
                    end
                    default: dec_d.illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                dec_d.op1  = bus.rs1_data_i;
                dec_d.op2  = imm_i;
                dec_d.ctrl = ALU_ADD;
            end
            OP_STORE: begin
                dec_d.op1        = bus.rs1_data_i;
                dec_d.op2        = imm_s;
                dec_d.ctrl       = ALU_ADD;
                dec_d.store_data = bus.rs2_data_i;
            end
            OP_LUI: begin
                dec_d.op2  = imm_u;
                dec_d.ctrl = ALU_ADD;
            end
            OP_AUIPC: begin
                dec_d.op1  = bus.pc_i;
                dec_d.op2  = imm_u;
                dec_d.ctrl = ALU_ADD;
            end
            OP_BRANCH: begin
                dec_d.op1       = bus.rs1_data_i;
                dec_d.op2       = bus.rs2_data_i;
                dec_d.ctrl      = ALU_SUB;
                dec_d.is_branch = 1'b1;
                dec_d.branch_ne = funct3[0];
                dec_d.illegal   = (funct3[2:1] != 2'b00);
            end
            default: dec_d.illegal = 1'b1;
        endcase
        // Illegal entries still flow downstream, but carry no operands or branch intent.
        if (dec_d.illegal) begin
            dec_d.op1        = '0;
            dec_d.op2        = '0;
            dec_d.store_data = '0;
            dec_d.ctrl       = ILLEGAL_CODE;
            dec_d.is_branch  = 1'b0;
            dec_d.branch_ne  = 1'b0;
        end
    end

    logic capture;
    assign bus.in_ready_o = !out_valid_q || bus.out_ready_i;
    assign capture        = bus.in_valid_i && bus.in_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
        end else if (bus.flush_i) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            dec_q       <= dec_d;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid_o   = out_valid_q;
    assign bus.operand1_o    = dec_q.op1;
    assign bus.operand2_o    = dec_q.op2;
    assign bus.alu_control_o = dec_q.ctrl;
    assign bus.is_branch_o   = dec_q.is_branch;
    assign bus.branch_ne_o   = dec_q.branch_ne;
    assign bus.store_data_o  = dec_q.store_data;
    assign bus.illegal_o     = dec_q.illegal;
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-issue stage of the pipelined RV32I core; the producer side of the ALU operand/control interface.
- Decodes an instruction into ALU inputs: operand1, operand2 and the 4-bit ALU control code, plus branch qualifiers.
- Registers the result in a 1-deep ID/EX pipeline register with valid/ready handshake, stall and flush.

Parameters:
- XLEN, 32, datapath width of pc, register data and operands.
- ILLEGAL_CODE, 4'b0000, alu_control_o value driven when the instruction is unsupported.

Ports:
- clk_i  input  1  core clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- in_valid_i  input  1  instr_i/pc_i/rs1_data_i/rs2_data_i are valid
- in_ready_o  output  1  stage can accept this cycle
- instr_i  input  32  instruction word
- pc_i  input  XLEN  pc of instr_i
- rs1_data_i  input  XLEN  register rs1 value, already forwarded
- rs2_data_i  input  XLEN  register rs2 value, already forwarded
- flush_i  input  1  kill stage contents (branch redirect)
- out_valid_o  output  1  registered outputs valid
- out_ready_i  input  1  ALU/EX consumer accepts
- operand1_o  output  XLEN  ALU operand1
- operand2_o  output  XLEN  ALU operand2
- alu_control_o  output  4  ALU control code
- is_branch_o  output  1  BEQ/BNE; EX resolves using the ALU zero flag
- branch_ne_o  output  1  1 = BNE (taken when zero=0); 0 = BEQ
- store_data_o  output  XLEN  rs2_data for S-type, else 0
- illegal_o  output  1  unsupported encoding

Behaviour:
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLL 0101, SRL 0110, SLTU 0111.
- Handshake: in_ready_o = !out_valid_o | out_ready_i (combinational). Capture when in_valid_i & in_ready_o. Latency 1 cycle.
- out_valid_o sets on capture. It clears on out_ready_i without a new capture.
- Outputs hold stable while out_valid_o & !out_ready_i.
- flush_i: out_valid_o <= 0 next edge. Flush has priority over a simultaneous capture; the input is dropped. in_ready_o is unaffected by flush.
- Reset (async, rst_ni=0): out_valid_o, all data outputs, is_branch_o, branch_ne_o, illegal_o = 0; in_ready_o = 1. Deassertion mid-stream: the first capture happens on the first edge with rst_ni=1 and in_valid_i=1.
- Decode, opcode [6:0]:
  - R-type 0110011: op1=rs1, op2=rs2, mapped per the ALU code table.
    - funct7=0100000 with funct3=000 gives SUB.
    - SLL/SRL: op2 = {27'b0, rs2[4:0]}.
  - I-ALU 0010011: op1=rs1, op2=sign-extended imm[31:20].
    - SLLI/SRLI: op2 = {27'b0, instr[24:20]}; instr[31:25] must be 0000000.
  - Load 0000011 / store 0100011: ADD with rs1 + sign-extended I/S immediate.
  - LUI 0110111: op1=0, op2={instr[31:12],12'b0}, ADD.
  - AUIPC 0010111: op1=pc, same op2, ADD.
  - BEQ/BNE 1100011, funct3 000/001: op1=rs1, op2=rs2, SUB, is_branch_o=1.
- Illegal: SLT, SLTI, SRA/SRAI, BLT/BGE/BLTU/BGEU, any other opcode, R-type funct7 not 0000000 (except SUB). On illegal:
  - alu_control_o = ILLEGAL_CODE, operands = 0, is_branch_o = 0, illegal_o = 1.
  - Still handshaken through as a valid entry.
- SLTU/SLTIU map to 0111; the ALU compare is unsigned. SLTIU's immediate is sign-extended, then compared unsigned.
- Shift amount is always masked to 5 bits; the ALU shifts by the full operand2.
- All arithmetic is XLEN-bit and wraps; no overflow flag.

Test Plan:
- ADD x3,x1,x2 (instr 0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, op1=5, op2=7, alu_control=0010, illegal=0.
- ADDI imm=-1 (0xFFF08093), rs1=0x10 -> op2=0xFFFFFFFF, alu_control=0010.
- SLL, rs2=0x00000023 -> op2=0x00000003, alu_control=0101.
- SRAI (0x4020D093) -> illegal_o=1, alu_control=0000, op1=op2=0.
- Backpressure: capture BNE (funct3 001), hold out_ready=0 for 3 cycles while presenting a new instr -> in_ready=0, outputs unchanged.
  - Then alu_control=0011, is_branch=1, branch_ne=1.
  - Raise out_ready -> new instr captured the same edge.
- Flush/reset: flush_i=1 with in_valid=1 -> out_valid=0 next cycle.
  - Pulse rst_ni=0 mid-stream -> all outputs 0 immediately (asynchronous), in_ready=1.
  - LUI 0x12345 after release -> op2=0x12345000, op1=0, alu_control=0010.
